// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that shares one registered adder between N_REQ requesters.
// A tag pipeline tracks in-flight ops, and each owner gets a held response register.
module adder_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 4,
    parameter int ADDER_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [N_REQ*WIDTH-1:0]   rsp_sum,
    output logic [N_REQ-1:0]         rsp_cout,
    output logic                     busy
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

    logic [N_REQ-1:0]       pending_q, pending_d;
    logic [IDW-1:0]         last_q, last_d;
    logic [ADDER_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [IDW-1:0]         tag_id_q [ADDER_LAT];
    logic [IDW-1:0]         tag_id_d [ADDER_LAT];
    logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [N_REQ*WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic [N_REQ-1:0]       rsp_cout_q, rsp_cout_d;

    logic [N_REQ-1:0]       elig;
    logic [N_REQ-1:0]       consume;
    logic                   grant_vld;
    logic [IDW-1:0]         grant_id;
    logic [IDW-1:0]         arb_idx;
    logic                   cap_vld;
    logic [IDW-1:0]         cap_id;

    // Gating with rst_n keeps req_ready and the adder operands quiet while reset is held.
    assign elig    = req_valid & ~pending_q & {N_REQ{rst_n}};
    assign consume = rsp_valid_q & rsp_ready;
    assign cap_vld = tag_vld_q[ADDER_LAT-1];
    assign cap_id  = tag_id_q[ADDER_LAT-1];

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        arb_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_idx = IDW'((int'(last_q) + k) % N_REQ);
            if (!grant_vld && elig[arb_idx]) begin
                grant_vld = 1'b1;
                grant_id  = arb_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
            add_a = req_a[grant_id*WIDTH +: WIDTH];
            add_b = req_b[grant_id*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        pending_d = pending_q & ~consume;
        last_d    = last_q;
        if (grant_vld) begin
            pending_d[grant_id] = 1'b1;
            last_d              = grant_id;
        end

        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = grant_vld;
        tag_id_d[0]  = grant_id;
        for (int s = 1; s < ADDER_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        // A capture never targets a held response: pending blocks that id's re-grant.
        rsp_valid_d = rsp_valid_q & ~consume;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (cap_vld) begin
            rsp_valid_d[cap_id]                = 1'b1;
            rsp_sum_d[cap_id*WIDTH +: WIDTH]   = add_sum;
            rsp_cout_d[cap_id]                 = add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            last_q      <= LAST_RST;
            tag_vld_q   <= '0;
            for (int s = 0; s < ADDER_LAT; s++) tag_id_q[s] <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            last_q      <= last_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = |pending_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model (pending set, due-cycle queue, a+b results).
module tb_adder_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_cout;
    logic [N*W-1:0] req_a = '0, req_b = '0, rsp_sum;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cout, busy;

    // Stand-in for the shared adder wrapper: input register, adder, output register.
    logic [W-1:0] a_r, b_r;
    always_ff @(posedge clk) begin
        a_r                 <= add_a;
        b_r                 <= add_b;
        {add_cout, add_sum} <= {1'b0, a_r} + {1'b0, b_r};
    end

    adder_share_arbiter #(.N_REQ(N), .WIDTH(W), .ADDER_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         id;
        int         due;
        logic [W:0] res;
    } op_t;

    op_t            inflight[$];
    logic [N-1:0]   m_pend, m_rspv, m_rcout;
    logic [N*W-1:0] m_rsum;
    int             m_last;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_rspv  = '0;
        m_rcout = '0;
        m_rsum  = '0;
        m_last  = N - 1;
        inflight.delete();
    endtask

    // One clock: drive at negedge, compare settled outputs, then advance the model across the edge.
    task automatic step(input logic [N-1:0] va, input logic [N*W-1:0] aa, input logic [N*W-1:0] ba,
                        input logic [N-1:0] rr, input logic rn);
        int           g;
        int           idx;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] ea, eb;
        logic [W:0]   s;
        @(negedge clk);
        req_valid = va;
        req_a     = aa;
        req_b     = ba;
        rsp_ready = rr;
        rst_n     = rn;
        if (!rn) model_reset();
        #1;
        g = -1;
        if (rn) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && va[idx] && !m_pend[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        ea      = '0;
        eb      = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ea = aa[g*W +: W];
            eb = ba[g*W +: W];
        end
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        check_eq("add_a",     64'(add_a),     64'(ea));
        check_eq("add_b",     64'(add_b),     64'(eb));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
        check_eq("rsp_sum",   64'(rsp_sum),   64'(m_rsum));
        check_eq("rsp_cout",  64'(rsp_cout),  64'(m_rcout));
        check_eq("busy",      64'(busy),      64'(|m_pend));
        for (int i = 0; i < N; i++) begin
            if (m_rspv[i] && rr[i]) begin
                m_rspv[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
        end
        if (g >= 0) begin
            m_pend[g] = 1'b1;
            m_last    = g;
            s = {1'b0, ea} + {1'b0, eb};
            inflight.push_back('{id: g, due: cyc + LAT + 1, res: s});
        end
        @(posedge clk);
        cyc++;
        for (int j = inflight.size() - 1; j >= 0; j--) begin
            if (inflight[j].due == cyc) begin
                m_rspv[inflight[j].id]             = 1'b1;
                m_rsum[inflight[j].id*W +: W]      = inflight[j].res[W-1:0];
                m_rcout[inflight[j].id]            = inflight[j].res[W];
                inflight.delete(j);
            end
        end
    endtask

    task automatic idle(input int n, input logic [N-1:0] rr);
        for (int i = 0; i < n; i++) step('0, '0, '0, rr, 1'b1);
    endtask

    initial begin
        model_reset();
        step('0, '0, '0, '0, 1'b0);
        step('0, '0, '0, '0, 1'b0);

        // Single op on requester 0: 3 + 5
        step(4'b0001, 16'h0003, 16'h0005, '0, 1'b1);
        idle(2, '0);
        #1;
        check_eq("single_rsp", 64'({rsp_valid[0], rsp_cout[0], rsp_sum[3:0]}), 64'({1'b1, 1'b0, 4'd8}));
        step('0, '0, '0, 4'b0001, 1'b1);
        #1;
        check_eq("single_done", 64'({rsp_valid[0], busy}), 64'(2'b00));

        // Overflow on requester 2
        step(4'b0100, 16'h0F00, 16'h0100, '0, 1'b1);
        idle(2, '0);
        #1;
        check_eq("ovf_15p1", 64'({rsp_cout[2], rsp_sum[11:8]}), 64'({1'b1, 4'd0}));
        step('0, '0, '0, 4'b0100, 1'b1);
        step(4'b0100, 16'h0F00, 16'h0F00, '0, 1'b1);
        idle(2, '0);
        #1;
        check_eq("ovf_15p15", 64'({rsp_cout[2], rsp_sum[11:8]}), 64'({1'b1, 4'd14}));
        step('0, '0, '0, 4'b0100, 1'b1);

        // Contention after reset: a = i+1, b = 2i
        step('0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b1111, 16'h4321, 16'h6420, 4'b1111, 1'b1);
        idle(4, 4'b1111);

        // Backpressure on requester 1 while 1 and 3 keep requesting
        for (int i = 0; i < 12; i++) step(4'b1010, 16'h5a5a, 16'h3c3c, 4'b1101, 1'b1);
        for (int i = 0; i < 6; i++)  step(4'b1010, 16'h1234, 16'h4321, 4'b1111, 1'b1);
        idle(4, 4'b1111);

        // Round-robin: last grant = 2, then 0 and 3 compete
        step(4'b0100, 16'h0700, 16'h0200, 4'b1111, 1'b1);
        step(4'b1001, 16'h9001, 16'h1002, 4'b1111, 1'b1);
        idle(5, 4'b1111);

        // Reset one cycle after a grant to requester 1
        step(4'b0010, 16'h00f0, 16'h0030, '0, 1'b1);
        step(4'b1111, 16'hffff, 16'hffff, 4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step('0, '0, '0, 4'b1111, 1'b1);
            #1;
            check_eq("rst_no_rsp", 64'(rsp_valid), 64'(0));
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(N'($urandom), (N*W)'($urandom), (N*W)'($urandom), N'($urandom),
                 ($urandom_range(0, 199) != 0));
        end
        idle(6, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter that shares one registered prefix adder (the `adder_*_wrapper` class: input register, combinational adder, output register; two-cycle latency) between `N_REQ` independent requesters. The arbiter:
- accepts operand pairs over per-requester valid/ready handshakes;
- issues at most one operation per cycle to the adder;
- tracks in-flight operations with a tag pipeline;
- returns each sum/carry to its owner through a held response register with valid/ready.

It sits between requesting datapath clients and a single adder instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 4, operand/sum width; must match the attached adder
- `ADDER_LAT`, 2, clocks from `add_a`/`add_b` presented to `add_sum`/`add_cout` valid
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  request present, per requester
- `req_ready`  out  N_REQ  one-hot grant; request accepted when valid&ready
- `req_a`  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  N_REQ*WIDTH  operand B, same packing
- `add_a`  out  WIDTH  adder operand A (to wrapper `a`)
- `add_b`  out  WIDTH  adder operand B (to wrapper `b`)
- `add_sum`  in  WIDTH  adder sum (from wrapper `sum`)
- `add_cout`  in  1  adder carry-out (from wrapper `cout`)
- `rsp_valid`  out  N_REQ  response held for requester i
- `rsp_ready`  in  N_REQ  requester i consumes response
- `rsp_sum`  out  N_REQ*WIDTH  held sum, same packing
- `rsp_cout`  out  N_REQ  held carry-out
- `busy`  out  1  OR of all pending flags

## Operation
- Per-requester `pending[i]`:
  - set on grant;
  - cleared at the edge where `rsp_valid[i] & rsp_ready[i]`.
- Eligibility: `elig[i] = req_valid[i] & ~pending[i]`. A requester has at most one operation outstanding.
- Arbitration is combinational, round-robin:
  - `last` holds the index of the most recent grant;
  - search order is last+1, last+2, … cyclic;
  - the first eligible index wins; `req_ready` is one-hot or all zero;
  - `last` updates only on a grant.
- `add_a`/`add_b`:
  - combinational mux of the granted requester's operands;
  - all-zero when there is no grant.
- Tag pipeline: `ADDER_LAT` stages of {valid, id[$clog2(N_REQ)-1:0]}, shifted every cycle. Stage 0 is loaded with the grant.
- Last tag stage valid → capture `add_sum`/`add_cout` into `rsp_sum[id]`/`rsp_cout[id]` and set `rsp_valid[id]`.
- Response registers hold unchanged until the handshake, then `rsp_valid` clears. `rsp_sum`/`rsp_cout` keep their last value.
- Capture cannot collide with a held response of the same id, because `pending` blocks re-grant until consumption.
- `req_valid` dropping without a grant is legal; no state changes.
- Arithmetic is the adder's: `sum = (a+b) mod 2^WIDTH`, `cout = bit WIDTH`. The arbiter does no arithmetic.

## Timing
- Reset (async assert, sync-safe deassert by system):
  - `pending`, `rsp_valid`, and all tag valids = 0;
  - `rsp_sum` = 0, `rsp_cout` = 0;
  - `last` = N_REQ-1, so requester 0 has first priority;
  - `busy` = 0.
- Outputs during reset: `req_ready` = 0 and `add_a`/`add_b` = 0, since no requester is eligible.
- Issue/response timing:
  - request granted in cycle t → adder input register loads at the end of t;
  - `add_sum` is valid in cycle t+ADDER_LAT and captured at the end of that cycle;
  - `rsp_valid[i]` is high from cycle t+ADDER_LAT+1 (t+3 at default).
- Throughput: one grant per cycle across distinct requesters.
- Same-requester reissue: if the response is consumed in cycle r, the earliest re-grant is cycle r+1.
- Simultaneous capture of id j and new grant to k≠j in the same cycle: both take effect.
- Reset mid-operation:
  - in-flight tags are discarded, and the adder's stale outputs are ignored;
  - no `rsp_valid` asserts after reset until a new grant has matured.
- `busy` is registered-derived: high from the cycle after the first grant until the cycle after the last consuming handshake.

## Test plan
- Single op: req0 valid, a=3 b=5, all others idle, granted cycle t → `rsp_valid[0]`=1 at t+3, `rsp_sum[0]`=8, `rsp_cout[0]`=0. With `rsp_ready[0]`=1 at t+3, `rsp_valid[0]`=0 at t+4 and `busy`=0 at t+4.
- Overflow: req2 a=15 b=1 → `rsp_sum[2]`=0, `rsp_cout[2]`=1; a=15 b=15 → sum 14, cout 1.
- Contention, cycle t after reset: all four requesters valid, operands i+1 and 2i. Required:
  - grants 0,1,2,3 in cycles t..t+3;
  - responses valid at t+3..t+6 with sums 1,4,7,10;
  - exactly one `req_ready` bit high per cycle.
- Backpressure fairness: `rsp_ready[1]`=0 held while req1 and req3 stay valid.
  - `rsp_valid[1]` holds its value;
  - req1 is never re-granted while blocked;
  - req3 is granted as soon as its own response is consumed.
  - Raising `rsp_ready[1]` makes req1 eligible the next cycle.
- Round-robin order: last grant=2 and requesters 0 and 3 both eligible → 3 is granted before 0.
- Reset mid-flight: grant req1 and deassert `rst_n` one cycle later for one cycle → `rsp_valid`=0, `pending`=0, `busy`=0 immediately, and no response appears in the following 5 cycles.
